histogram_scan: RTL and testbench

- Downstream consumer of the sliding-window histogram stage. It sweeps every histogram bin through that stage's HisMemRD/HisMemRDAdd/HisMemRDData read port.
- Per sweep it reports:
  - the mode bin and its count;
  - the number of non-zero bins;
  - an alarm flag when the mode count reaches a programmable threshold.
- Reads are issued only in cycles that cannot collide with the histogram's internal add/subtract accesses, which take read-port priority.

---
 rtl/histogram_scan_pkg.sv | 23 ++
 rtl/histogram_scan_acc.sv | 45 ++++
 rtl/histogram_scan.sv | 147 ++++++++++++++
 tb/tb_histogram_scan.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : histogram_scan_pkg
// Description : Shared state encoding and read-port timing constants for the
//               histogram stage and its scan consumer.
// Revision    : 1.0 - initial release
// ============================================================================
package histogram_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scanState_t;

  // Cycles from HisMemRD to HisMemRDData, and the Valid-history tap that
  // drives the histogram's subtract read.
  localparam int RD_LAT    = 2;
  localparam int GUARD_TAP = 2;

endpackage
`default_nettype wire

// File: rtl/histogram_scan_acc.sv
`default_nettype none
// ============================================================================
// Module      : histogram_scan_acc
// Description : Running maximum / lowest-index mode bin / non-zero counter
//               over returned bin counts.
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_scan_acc #(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   hit,
  input  logic [DATA_SIZE-1:0]   bin,
  input  logic [LENGTH_SIZE-1:0] data,
  output logic [LENGTH_SIZE-1:0] runMax,
  output logic [DATA_SIZE-1:0]   runBin,
  output logic [DATA_SIZE:0]     nzCount
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      runMax  <= '0;
      runBin  <= '0;
      nzCount <= '0;
    end else if (clear) begin
      runMax  <= '0;
      runBin  <= '0;
      nzCount <= '0;
    end else if (hit) begin
      if (data != '0) begin
        nzCount <= nzCount + 1'b1;
      end
      // Strict compare: on a tie the earlier (lower) bin is kept.
      if (data > runMax) begin
        runMax <= data;
        runBin <= bin;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/histogram_scan.sv
`default_nettype none
// ============================================================================
// Module      : histogram_scan
// Description : Sweeps all histogram bins through the shared read port in
//               collision-free cycles and reports mode, non-zero count, alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_scan
  import histogram_scan_pkg::*;
#(
  parameter int DATA_SIZE   = 4,
  parameter int DATA_NUM    = 16,
  parameter int LENGTH_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   Valid,
  input  logic                   ScanStart,
  input  logic [LENGTH_SIZE-1:0] Threshold,
  output logic                   HisMemRD,
  output logic [DATA_SIZE-1:0]   HisMemRDAdd,
  input  logic [LENGTH_SIZE-1:0] HisMemRDData,
  output logic                   Busy,
  output logic                   ScanDone,
  output logic [DATA_SIZE-1:0]   ModeBin,
  output logic [LENGTH_SIZE-1:0] ModeCount,
  output logic [DATA_SIZE:0]     NonZeroBins,
  output logic                   Alarm
);

  scanState_t             r_state;
  scanState_t             w_nextState;
  logic [GUARD_TAP:0]     r_vhist;
  logic [DATA_SIZE-1:0]   r_addr;
  logic [LENGTH_SIZE-1:0] r_threshold;
  logic [RD_LAT-1:0]      r_tagValid;
  logic [DATA_SIZE-1:0]   r_tagAddr [RD_LAT];
  logic                   w_allowed;
  logic                   w_grant;
  logic                   w_lastBin;
  logic                   w_tagsEmpty;
  logic                   w_start;
  logic [LENGTH_SIZE-1:0] w_runMax;
  logic [DATA_SIZE-1:0]   w_runBin;
  logic [DATA_SIZE:0]     w_nzCount;

  // The histogram's add read uses the current Valid, its subtract read the
  // Valid of three cycles ago; both own the port in those cycles.
  assign w_allowed   = !Valid && !r_vhist[GUARD_TAP];
  assign w_grant     = (r_state == ISSUE) && w_allowed;
  assign w_lastBin   = (r_addr == DATA_SIZE'(DATA_NUM - 1));
  assign w_tagsEmpty = ~|r_tagValid;
  assign HisMemRD    = w_grant;
  assign HisMemRDAdd = r_addr;

  always_comb begin
    w_nextState = r_state;
    Busy        = 1'b0;
    ScanDone    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (ScanStart) begin
          w_start     = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        Busy = 1'b1;
        if (w_grant && w_lastBin) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        Busy = 1'b1;
        if (w_tagsEmpty) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        ScanDone    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_vhist     <= '0;
      r_addr      <= '0;
      r_threshold <= '0;
      r_tagValid  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tagAddr[i] <= '0;
      end
    end else begin
      r_state      <= w_nextState;
      r_vhist      <= {r_vhist[GUARD_TAP-1:0], Valid};
      r_tagValid   <= {r_tagValid[RD_LAT-2:0], w_grant};
      r_tagAddr[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tagAddr[i] <= r_tagAddr[i-1];
      end
      if (w_start) begin
        r_threshold <= Threshold;
        r_addr      <= '0;
      end else if (w_grant) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  histogram_scan_acc #(
    .DATA_SIZE  (DATA_SIZE),
    .LENGTH_SIZE(LENGTH_SIZE)
  ) u_acc (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (w_start),
    .hit    (r_tagValid[RD_LAT-1]),
    .bin    (r_tagAddr[RD_LAT-1]),
    .data   (HisMemRDData),
    .runMax (w_runMax),
    .runBin (w_runBin),
    .nzCount(w_nzCount)
  );

  // Results are captured as DRAIN hands over, so they are already visible
  // during the ScanDone cycle and hold until the next sweep completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ModeBin     <= '0;
      ModeCount   <= '0;
      NonZeroBins <= '0;
      Alarm       <= 1'b0;
    end else if ((r_state == DRAIN) && w_tagsEmpty) begin
      ModeBin     <= w_runBin;
      ModeCount   <= w_runMax;
      NonZeroBins <= w_nzCount;
      Alarm       <= (w_runMax >= r_threshold);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_histogram_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_histogram_scan
// Description : Scoreboard bench for histogram_scan with a behavioural
//               histogram read-port model and randomized sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_histogram_scan;

  localparam int c_DS = 4;
  localparam int c_DN = 16;
  localparam int c_LS = 6;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            Valid = 1'b0;
  logic            ScanStart = 1'b0;
  logic [c_LS-1:0] Threshold = '0;
  logic            HisMemRD;
  logic [c_DS-1:0] HisMemRDAdd;
  logic [c_LS-1:0] HisMemRDData;
  logic            Busy;
  logic            ScanDone;
  logic [c_DS-1:0] ModeBin;
  logic [c_LS-1:0] ModeCount;
  logic [c_DS:0]   NonZeroBins;
  logic            Alarm;

  histogram_scan #(
    .DATA_SIZE  (c_DS),
    .DATA_NUM   (c_DN),
    .LENGTH_SIZE(c_LS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .Valid       (Valid),
    .ScanStart   (ScanStart),
    .Threshold   (Threshold),
    .HisMemRD    (HisMemRD),
    .HisMemRDAdd (HisMemRDAdd),
    .HisMemRDData(HisMemRDData),
    .Busy        (Busy),
    .ScanDone    (ScanDone),
    .ModeBin     (ModeBin),
    .ModeCount   (ModeCount),
    .NonZeroBins (NonZeroBins),
    .Alarm       (Alarm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Histogram memory with a two-cycle read; unread cycles return noise.
  logic [c_LS-1:0] mem [c_DN];
  logic [c_LS-1:0] rdPipe1, rdPipe2;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdPipe1 <= '0;
      rdPipe2 <= '0;
    end else begin
      rdPipe1 <= HisMemRD ? mem[HisMemRDAdd] : c_LS'($urandom);
      rdPipe2 <= rdPipe1;
    end
  end
  assign HisMemRDData = rdPipe2;

  typedef struct {
    int bin;
    int cnt;
    int nz;
    int alarm;
  } exp_t;
  exp_t expQ[$];

  // Mode = maximum count, reported at the first bin holding that count.
  function automatic exp_t model(input int thr);
    exp_t r;
    int best = 0;
    r.nz = 0;
    r.bin = -1;
    for (int i = 0; i < c_DN; i++) begin
      if (int'(mem[i]) > best) best = int'(mem[i]);
      if (mem[i] != 0) r.nz++;
    end
    for (int i = 0; i < c_DN; i++) begin
      if (int'(mem[i]) == best && r.bin < 0) r.bin = i;
    end
    r.cnt = best;
    r.alarm = (best >= thr) ? 1 : 0;
    return r;
  endfunction

  // Monitor: read-port legality, bin order, and results against the queue.
  logic [2:0] vh = '0;
  bit sweepActive = 1'b0;
  int startCyc = 0, allowedSeen = 0, lastBinCyc = 0;
  int doneCount = 0, lastDoneCyc = 0, lastStartCyc = 0;

  always @(negedge clk) begin
    bit   allowed;
    bit   expRd;
    exp_t e;
    if (!rstn) begin
      vh = '0;
      sweepActive = 1'b0;
    end else begin
      allowed = !Valid && !vh[2];
      expRd = sweepActive && (cyc > startCyc) && (allowedSeen < c_DN) && allowed;
      chk("guard", int'(HisMemRD && !allowed), 0);
      chk("HisMemRD", int'(HisMemRD), int'(expRd));
      if (expRd) begin
        chk("HisMemRDAdd", int'(HisMemRDAdd), allowedSeen);
        allowedSeen++;
        if (allowedSeen == c_DN) lastBinCyc = cyc;
      end
      if (ScanStart && !sweepActive) begin
        sweepActive = 1'b1;
        startCyc = cyc;
        lastStartCyc = cyc;
        allowedSeen = 0;
      end
      if (ScanDone) begin
        doneCount++;
        lastDoneCyc = cyc;
        if (!sweepActive || expQ.size() == 0) begin
          chk("spurious ScanDone", 1, 0);
        end else begin
          e = expQ.pop_front();
          chk("ModeBin", int'(ModeBin), e.bin);
          chk("ModeCount", int'(ModeCount), e.cnt);
          chk("NonZeroBins", int'(NonZeroBins), e.nz);
          chk("Alarm", int'(Alarm), e.alarm);
          chk("reads", allowedSeen, c_DN);
          chk("latency", cyc, lastBinCyc + 4);
        end
        sweepActive = 1'b0;
      end
      vh = {vh[1:0], Valid};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMem();
    for (int i = 0; i < c_DN; i++) mem[i] = '0;
  endtask

  task automatic startSweep(input int thr);
    expQ.push_back(model(thr));
    Threshold = c_LS'(thr);
    ScanStart = 1'b1;
    tick();
    ScanStart = 1'b0;
    Threshold = c_LS'($urandom);
  endtask

  task automatic waitDone(input bit noise);
    int d0 = doneCount;
    int n = 0;
    while (doneCount == d0 && n < 300) begin
      Valid = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
      n++;
    end
    Valid = 1'b0;
    if (doneCount == d0) chk("ScanDone timeout", 0, 1);
  endtask

  initial begin
    int d;
    #1 rstn = 1'b0;
    clearMem();
    repeat (3) tick();
    chk("reset ModeBin", int'(ModeBin), 0);
    chk("reset ModeCount", int'(ModeCount), 0);
    chk("reset NonZeroBins", int'(NonZeroBins), 0);
    chk("reset Alarm", int'(Alarm), 0);
    chk("reset Busy", int'(Busy), 0);
    chk("reset ScanDone", int'(ScanDone), 0);
    rstn = 1'b1;
    repeat (2) tick();

    // Sparse histogram, no traffic.
    clearMem();
    mem[3] = 5; mem[7] = 9; mem[12] = 2;
    startSweep(8);
    waitDone(1'b0);
    chk("latency best case", lastDoneCyc - lastStartCyc, 20);

    // Tie keeps lowest index.
    clearMem();
    mem[2] = 6; mem[9] = 6;
    startSweep(7);
    waitDone(1'b0);

    // Single Valid pulse at sweep cycle 5 blocks cycles 5 and 8.
    for (int i = 0; i < c_DN; i++) mem[i] = c_LS'($urandom);
    startSweep(30);
    while (cyc < lastStartCyc + 5) tick();
    Valid = 1'b1;
    @(negedge clk);
    chk("blocked by Valid", int'(HisMemRD), 0);
    tick();
    Valid = 1'b0;
    while (cyc < lastStartCyc + 8) tick();
    @(negedge clk);
    chk("blocked by Valid-3", int'(HisMemRD), 0);
    waitDone(1'b0);
    chk("latency one pulse", lastDoneCyc - lastStartCyc, 22);

    // All-zero histogram, threshold 0 and non-zero.
    clearMem();
    startSweep(0);
    waitDone(1'b0);
    startSweep(5);
    waitDone(1'b0);

    // Every bin populated.
    for (int i = 0; i < c_DN; i++) mem[i] = c_LS'($urandom_range(1, 63));
    startSweep(40);
    waitDone(1'b0);

    // ScanStart while busy is ignored.
    for (int i = 0; i < c_DN; i++) mem[i] = c_LS'($urandom_range(1, 63));
    startSweep(10);
    repeat (3) tick();
    chk("Busy mid-sweep", int'(Busy), 1);
    ScanStart = 1'b1;
    tick();
    ScanStart = 1'b0;
    waitDone(1'b0);
    d = doneCount;
    repeat (30) tick();
    chk("single ScanDone", doneCount, d);

    // Reset during ISSUE abandons the sweep.
    startSweep(10);
    repeat (6) tick();
    rstn = 1'b0;
    void'(expQ.pop_back());
    #1;
    chk("mid reset ModeBin", int'(ModeBin), 0);
    chk("mid reset ModeCount", int'(ModeCount), 0);
    chk("mid reset NonZeroBins", int'(NonZeroBins), 0);
    chk("mid reset Alarm", int'(Alarm), 0);
    chk("mid reset Busy", int'(Busy), 0);
    chk("mid reset HisMemRD", int'(HisMemRD), 0);
    repeat (2) tick();
    rstn = 1'b1;
    d = doneCount;
    repeat (30) tick();
    chk("no ScanDone after reset", doneCount, d);
    clearMem();
    mem[0] = 1; mem[15] = 33; mem[8] = 33;
    startSweep(33);
    waitDone(1'b0);

    // Randomized sweeps under Valid traffic.
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < c_DN; i++) begin
        mem[i] = ($urandom_range(0, 9) < 4) ? '0 : c_LS'($urandom);
      end
      startSweep(int'($urandom_range(0, 63)));
      waitDone(1'b1);
      repeat (2) tick();
    end

    chk("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
